// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, qualifies lock, releases sys_reset.
// Keeps saturating lock-loss and lock-timeout event counts for status readout.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RELEASE_HOLD_CYCLES = 64,
  parameter int CNT_W               = 16,
  parameter int EVT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked_in,
  output logic             pll_rst,
  output logic             sys_reset,
  output logic             ready,
  output logic [EVT_W-1:0] lock_loss_count,
  output logic [EVT_W-1:0] timeout_count,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HLD_LAST =
    CNT_W'(RELEASE_HOLD_CYCLES - 1);
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sync1;
  logic             lock_s;
  logic             loss_evt;
  logic             tmo_evt;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= locked_in;
      lock_s <= sync1;
    end
  end

  always_comb begin
    state_nxt = state;
    loss_evt  = 1'b0;
    tmo_evt   = 1'b0;
    case (state)
      S_PLL_RST: begin
        if (cnt == RST_LAST)
          state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = S_STABLE;
        end else if (cnt == TMO_LAST) begin
          state_nxt = S_PLL_RST;
          tmo_evt   = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s)
          state_nxt = S_WAIT_LOCK;
        else if (cnt == STB_LAST)
          state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (!lock_s)
          state_nxt = S_WAIT_LOCK;
        else if (cnt == HLD_LAST)
          state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!lock_s) begin
          state_nxt = S_PLL_RST;
          loss_evt  = 1'b1;
        end
      end
      default: state_nxt = S_PLL_RST;
    endcase
  end

  // cnt is the time spent in the current state; any transition restarts it
  always_comb begin
    cnt_nxt = cnt + 1'b1;
    if (state_nxt != state)
      cnt_nxt = '0;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= S_PLL_RST;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // outputs decoded from next state so they line up with the state register
  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      pll_rst   <= (state_nxt == S_PLL_RST);
      sys_reset <= (state_nxt != S_RUN);
      ready     <= (state_nxt == S_RUN);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_loss_count <= '0;
      timeout_count   <= '0;
    end else begin
      if (loss_evt && lock_loss_count != EVT_MAX)
        lock_loss_count <= lock_loss_count + 1'b1;
      if (tmo_evt && timeout_count != EVT_MAX)
        timeout_count <= timeout_count + 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer.
// Inputs change and outputs are sampled on the falling edge.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst;
  logic       locked_in;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic [7:0] timeout_count;
  logic [2:0] state_o;

  int tests;
  int fails;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .RELEASE_HOLD_CYCLES (4),
    .CNT_W               (16),
    .EVT_W               (8)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .locked_in       (locked_in),
    .pll_rst         (pll_rst),
    .sys_reset       (sys_reset),
    .ready           (ready),
    .lock_loss_count (lock_loss_count),
    .timeout_count   (timeout_count),
    .state_o         (state_o)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    locked_in = 1'b0;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    locked_in = 1'b0;

    // reset state
    run(2);
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_sys_reset", 32'(sys_reset), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_loss", 32'(lock_loss_count), 0);
    chk("rst_tmo", 32'(timeout_count), 0);

    // 1: bring-up
    do_reset();
    run(3);
    chk("bu_pll_rst_p3", 32'(pll_rst), 1);
    run(1);
    chk("bu_pll_rst_p4", 32'(pll_rst), 0);
    chk("bu_state_p4", 32'(state_o), 1);
    run(5);
    locked_in = 1'b1;
    run(2);
    chk("bu_state_sync", 32'(state_o), 1);
    run(1);
    chk("bu_state_stable", 32'(state_o), 2);
    run(11);
    chk("bu_ready_e14", 32'(ready), 0);
    chk("bu_sysrst_e14", 32'(sys_reset), 1);
    chk("bu_state_hold", 32'(state_o), 3);
    run(1);
    chk("bu_ready_e15", 32'(ready), 1);
    chk("bu_sysrst_e15", 32'(sys_reset), 0);
    chk("bu_state_run", 32'(state_o), 4);
    chk("bu_loss", 32'(lock_loss_count), 0);
    chk("bu_tmo", 32'(timeout_count), 0);

    // 4: lock loss in RUN, then relock
    run(3);
    locked_in = 1'b0;
    run(2);
    chk("loss_ready_e2", 32'(ready), 1);
    chk("loss_sysrst_e2", 32'(sys_reset), 0);
    run(1);
    chk("loss_ready_e3", 32'(ready), 0);
    chk("loss_sysrst_e3", 32'(sys_reset), 1);
    chk("loss_pll_rst", 32'(pll_rst), 1);
    chk("loss_state", 32'(state_o), 0);
    chk("loss_count", 32'(lock_loss_count), 1);
    run(3);
    chk("loss_pulse_p3", 32'(pll_rst), 1);
    run(1);
    chk("loss_pulse_p4", 32'(pll_rst), 0);
    chk("loss_wait", 32'(state_o), 1);
    locked_in = 1'b1;
    run(14);
    chk("relock_ready_e14", 32'(ready), 0);
    run(1);
    chk("relock_ready_e15", 32'(ready), 1);
    chk("relock_state", 32'(state_o), 4);
    chk("relock_loss", 32'(lock_loss_count), 1);

    // 2: no lock, repeated timeouts
    do_reset();
    for (int p = 1; p <= 3; p++) begin
      run(23);
      chk("nl_pll_rst_low", 32'(pll_rst), 0);
      chk("nl_state_wait", 32'(state_o), 1);
      chk("nl_tmo_before", 32'(timeout_count), p - 1);
      run(1);
      chk("nl_pll_rst_high", 32'(pll_rst), 1);
      chk("nl_tmo", 32'(timeout_count), p);
      chk("nl_sysrst", 32'(sys_reset), 1);
      chk("nl_ready", 32'(ready), 0);
    end

    // 3: one-cycle glitch in STABLE
    do_reset();
    run(4);
    locked_in = 1'b1;
    run(5);
    locked_in = 1'b0;
    run(1);
    locked_in = 1'b1;
    run(1);
    chk("gl_state_stable", 32'(state_o), 2);
    run(1);
    chk("gl_state_wait", 32'(state_o), 1);
    run(1);
    chk("gl_state_restable", 32'(state_o), 2);
    run(6);
    chk("gl_ready_nominal", 32'(ready), 0);
    run(5);
    chk("gl_state_hold", 32'(state_o), 3);
    chk("gl_ready_e19", 32'(ready), 0);
    run(1);
    chk("gl_ready_e20", 32'(ready), 1);
    chk("gl_loss", 32'(lock_loss_count), 0);

    // 5: lock-loss saturation
    for (int i = 1; i <= 260; i++) begin
      locked_in = 1'b0;
      run(3);
      if (i == 1 || i >= 254)
        chk("sat_loss", 32'(lock_loss_count),
            (i > 255) ? 255 : i);
      run(4);
      locked_in = 1'b1;
      run(15);
    end
    chk("sat_state_run", 32'(state_o), 4);
    chk("sat_tmo", 32'(timeout_count), 0);

    // 6: rst in HOLD
    locked_in = 1'b0;
    run(3);
    chk("sat_hold_255", 32'(lock_loss_count), 255);
    run(4);
    locked_in = 1'b1;
    run(12);
    chk("mid_state_hold", 32'(state_o), 3);
    rst = 1'b1;
    run(1);
    chk("mid_pll_rst", 32'(pll_rst), 1);
    chk("mid_sysrst", 32'(sys_reset), 1);
    chk("mid_ready", 32'(ready), 0);
    chk("mid_loss", 32'(lock_loss_count), 0);
    chk("mid_tmo", 32'(timeout_count), 0);
    chk("mid_state", 32'(state_o), 0);
    rst = 1'b0;
    run(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
